// File: rtl/mux_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_pkg
// Shared definitions for the round-robin mux arbiter:
//   - state_t : FSM state encoding (ST_IDLE = 1'b0, ST_BUSY = 1'b1)
//   - DEF_N   : default number of requesters
//   - DEF_W   : default data width per requester
// No ports.
// -----------------------------------------------------------------------------
package mux_rr_arbiter_pkg;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_if
// Bundles the requester side, the downstream side and the status/debug
// signals of the arbiter.
//   in_valid/in_data/in_last : N requesters, producer -> arbiter
//   in_ready                 : per-requester ready, arbiter -> producer
//   out_valid/out_data/out_last, out_ready : single downstream channel
//   grant, busy              : registered one-hot grant and burst-active flag
//   dbg_state/dbg_ptr/dbg_idx: FSM state and round-robin registers, read-only
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; valid never waits for ready, and data/last are meaningful only while
// valid is high.
// Modports: slave = arbiter, master = producers/consumer/bench.
// -----------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int IDXW = 2
);
   import mux_rr_arbiter_pkg::*;

   logic [N-1:0]    in_valid;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic            out_last;
   logic            out_ready;
   logic [N-1:0]    grant;
   logic            busy;
   state_t          dbg_state;
   logic [IDXW-1:0] dbg_ptr;
   logic [IDXW-1:0] dbg_idx;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, grant, busy,
             dbg_state, dbg_ptr, dbg_idx
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, grant, busy,
             dbg_state, dbg_ptr, dbg_idx
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first set bit of req at or
// after ptr, searching upward modulo N.
//   req    [N]    : request vector
//   ptr    [IDXW] : search start position (must be < N)
//   found         : any request present
//   idx    [IDXW] : index of the selected request (0 when none)
//   onehot [N]    : one-hot form of idx (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N    = 4,
   parameter int IDXW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic            found,
   output logic [IDXW-1:0] idx,
   output logic [N-1:0]    onehot
);

   always_comb begin
      found  = 1'b0;
      idx    = '0;
      onehot = '0;
      // Walk N positions starting at ptr; the first hit wins.
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            found                            = 1'b1;
            idx                              = IDXW'((int'(ptr) + k) % N);
            onehot[(int'(ptr) + k) % N]      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter driving the select of an N-to-1 mux. A requester is
// granted in IDLE and keeps the grant for a whole burst, which ends on the
// transferred beat that carries last. The grant is registered, so a new
// burst always starts one cycle after the request is seen.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_arbiter_if.slave (requesters, downstream, grant/busy,
//           debug view of state/ptr/idx)
// -----------------------------------------------------------------------------
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int W    = DEF_W,
   parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   mux_rr_arbiter_if.slave    bus
);

   state_t          r_state,  w_state_nxt;
   logic [N-1:0]    r_grant,  w_grant_nxt;
   logic [IDXW-1:0] r_idx,    w_idx_nxt;
   logic [IDXW-1:0] r_ptr,    w_ptr_nxt;

   logic            w_found;
   logic [IDXW-1:0] w_pick_idx;
   logic [N-1:0]    w_pick_onehot;

   logic            w_out_valid;
   logic [W-1:0]    w_out_data;
   logic            w_out_last;
   logic [N-1:0]    w_in_ready;
   logic            w_xfer;

   rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
      .req    (bus.in_valid),
      .ptr    (r_ptr),
      .found  (w_found),
      .idx    (w_pick_idx),
      .onehot (w_pick_onehot)
   );

   // Output mux: everything is gated by BUSY so IDLE (and reset) drive zeros.
   always_comb begin
      w_out_valid = 1'b0;
      w_out_data  = '0;
      w_out_last  = 1'b0;
      w_in_ready  = '0;
      if (r_state == ST_BUSY) begin
         w_out_valid       = bus.in_valid[r_idx];
         w_out_data        = bus.in_data[int'(r_idx)*W +: W];
         w_out_last        = bus.in_last[r_idx];
         w_in_ready[r_idx] = bus.out_ready;
      end
   end

   assign w_xfer = w_out_valid && bus.out_ready;

   // Next-state logic. ptr moves only when a burst closes, which is what
   // keeps the rotation fair regardless of burst length.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_BUSY;
               w_grant_nxt = w_pick_onehot;
               w_idx_nxt   = w_pick_idx;
            end
         end
         ST_BUSY: begin
            if (w_xfer && w_out_last) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
               w_ptr_nxt   = (r_idx == IDXW'(N - 1)) ? '0 : r_idx + IDXW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_data;
   assign bus.out_last  = w_out_last;
   assign bus.in_ready  = w_in_ready;
   assign bus.grant     = r_grant;
   assign bus.busy      = (r_state == ST_BUSY);
   assign bus.dbg_state = r_state;
   assign bus.dbg_ptr   = r_ptr;
   assign bus.dbg_idx   = r_idx;

endmodule
